// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the fetch and decode stages:
// NOP encoding, fetch FSM states, default reset vector and base opcodes.
package rv32i_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_BUF  = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding memory request, a one-entry skid
// buffer for responses that arrive while decode stalls, and the IF/ID register.
module fetch_stage
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_valid_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc4_o,
  output logic [6:0]  opcode_o,
  output logic [2:0]  funct3_o,
  output logic [6:0]  funct7_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o
);

  localparam logic [1:0] ST_REQ  = FETCH_REQ;
  localparam logic [1:0] ST_BUF  = FETCH_BUF;
  localparam logic [1:0] ST_DROP = FETCH_DROP;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_dropAddr;
  logic        r_bufValid;
  logic [31:0] r_bufInstr;
  logic [31:0] r_bufPc;
  logic        r_ifValid;
  logic [31:0] r_ifInstr;
  logic [31:0] r_ifPc;

  logic        w_accept;
  logic [31:0] w_target;
  logic        w_unused;

  assign imem_req_o  = (r_state != ST_BUF);
  assign imem_addr_o = (r_state == ST_DROP) ? r_dropAddr : r_pc;
  assign w_accept    = imem_req_o && imem_valid_i;
  assign w_target    = align_word(redirect_pc_i);
  assign w_unused    = ^redirect_pc_i[1:0];

  // Flush outranks stall and any response; a request that is still in flight
  // when flushed keeps its address in DROP so the memory sees a stable request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_REQ;
      r_pc       <= RESET_PC;
      r_dropAddr <= 32'h0;
      r_bufValid <= 1'b0;
      r_bufInstr <= 32'h0;
      r_bufPc    <= 32'h0;
      r_ifValid  <= 1'b0;
      r_ifInstr  <= NOP_INSTR;
      r_ifPc     <= 32'h0;
    end else if (flush_i) begin
      r_ifValid  <= 1'b0;
      r_ifInstr  <= NOP_INSTR;
      r_pc       <= w_target;
      r_bufValid <= 1'b0;
      case (r_state)
        ST_REQ: begin
          if (!w_accept) begin
            r_dropAddr <= r_pc;
            r_state    <= ST_DROP;
          end
        end
        ST_BUF:  r_state <= ST_REQ;
        ST_DROP: if (w_accept) r_state <= ST_REQ;
        default: r_state <= ST_REQ;
      endcase
    end else begin
      case (r_state)
        ST_REQ: begin
          if (w_accept) begin
            r_pc <= r_pc + 32'd4;
            if (stall_i) begin
              r_bufValid <= 1'b1;
              r_bufInstr <= imem_rdata_i;
              r_bufPc    <= r_pc;
              r_state    <= ST_BUF;
            end else begin
              r_ifValid <= 1'b1;
              r_ifInstr <= imem_rdata_i;
              r_ifPc    <= r_pc;
            end
          end else if (!stall_i) begin
            r_ifValid <= 1'b0;
            r_ifInstr <= NOP_INSTR;
          end
        end
        ST_BUF: begin
          if (!stall_i) begin
            r_ifValid  <= 1'b1;
            r_ifInstr  <= r_bufInstr;
            r_ifPc     <= r_bufPc;
            r_bufValid <= 1'b0;
            r_state    <= ST_REQ;
          end
        end
        ST_DROP: begin
          if (w_accept) r_state <= ST_REQ;
          if (!stall_i) begin
            r_ifValid <= 1'b0;
            r_ifInstr <= NOP_INSTR;
          end
        end
        default: r_state <= ST_REQ;
      endcase
    end
  end

  assign if_id_valid_o = r_ifValid;
  assign if_id_instr_o = r_ifInstr;
  assign if_id_pc_o    = r_ifPc;
  assign if_id_pc4_o   = r_ifPc + 32'd4;

  assign opcode_o = r_ifInstr[6:0];
  assign rd_o     = r_ifInstr[11:7];
  assign funct3_o = r_ifInstr[14:12];
  assign rs1_o    = r_ifInstr[19:15];
  assign rs2_o    = r_ifInstr[24:20];
  assign funct7_o = r_ifInstr[31:25];

endmodule
